// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int DW   = 64;
    localparam int BE_W = DW / 8;

    // Ceiling log2, clamped to at least one bit so a one-entry array still indexes.
    function automatic int idx_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < depth) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: asynchronous read, synchronous byte-enabled write.
// Define DMEM_INIT_EN to preload the contents with zeros at time zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IW    = idx_w(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [BE_W-1:0] be_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

`ifdef DMEM_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end
`else
`endif

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave: one access at a time, fixed LATENCY from acceptance
// to response, byte-enable stores, misaligned/out-of-range error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [63:0]     req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [BE_W-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o
);

    localparam int IW = idx_w(DEPTH);
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            ready_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;
    logic            we_q;
    logic [63:0]     addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BE_W-1:0] be_q;

    logic            access_d;
    logic            err_d;
    logic            wr_en_d;
    logic [DW-1:0]   rsp_rdata_d;
    logic [DW-1:0]   arr_rdata;

    // The access happens on the edge that ends the last BUSY cycle.
    assign access_d    = (state_q == BUSY) && (cnt_q == 4'd0);
    assign err_d       = (addr_q[2:0] != 3'd0) || (addr_q >= LIMIT);
    assign wr_en_d     = access_d && we_q && !err_d;
    assign rsp_rdata_d = (we_q || err_d) ? '0 : arr_rdata;

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (wr_en_d),
        .addr_i  (addr_q[3 +: IW]),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid_i && ready_q) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= err_d;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=128, LATENCY=2) with immediate assertions.
module tb_dmem_responder;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    int tests;
    int fails;

    dmem_responder #(
        .DEPTH   (128),
        .LATENCY (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic drive_req(input logic we, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    // Counts edges from acceptance until rsp_valid_o is seen; bounded.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd2);
    endtask

    task automatic txn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be,
                       input logic [63:0] exp_rdata, input logic exp_err);
        wait_ready(tag);
        drive_req(we, addr, wdata, be);
        wait_rsp(tag);
        check({tag, "_rdata"}, rsp_rdata_o, exp_rdata);
        check({tag, "_err"}, 64'(rsp_err_o), 64'(exp_err));
        @(posedge clk_i); #1;
        check({tag, "_valid_drop"}, 64'(rsp_valid_o), 64'd0);
        $display("[TB] %s we=%0d addr=0x%h rdata=0x%h err=%0d", tag, we, addr, exp_rdata, exp_err);
    endtask

    initial begin
        logic [63:0] held;
        int          seen;
        tests       = 0;
        fails       = 0;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b1;

        #1 rst_i = 1'b1;
        #2;
        check("rst_ready_low", 64'(req_ready_o), 64'd0);
        check("rst_valid_low", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("rel_ready", 64'(req_ready_o), 64'd1);
        check("rel_valid", 64'(rsp_valid_o), 64'd0);
        check("rel_rdata", rsp_rdata_o, 64'd0);
        check("rel_err", 64'(rsp_err_o), 64'd0);

        txn("st_idx0",  1'b1, 64'h0,   64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0);
        txn("st_full",  1'b1, 64'h10,  64'h1122334455667788, 8'hFF, 64'h0, 1'b0);
        txn("ld_full",  1'b0, 64'h10,  64'h0,                8'h00, 64'h1122334455667788, 1'b0);
        txn("st_merge", 1'b1, 64'h10,  64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0, 1'b0);
        txn("ld_merge", 1'b0, 64'h10,  64'h0,                8'hFF, 64'h11223344BBBBBBBB, 1'b0);
        txn("st_be0",   1'b1, 64'h10,  64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0);
        txn("ld_be0",   1'b0, 64'h10,  64'h0,                8'h00, 64'h11223344BBBBBBBB, 1'b0);
        txn("ld_misal", 1'b0, 64'h13,  64'h0,                8'h00, 64'h0, 1'b1);
        txn("st_oor",   1'b1, 64'h400, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1);
        txn("ld_idx0",  1'b0, 64'h0,   64'h0,                8'h00, 64'h0123456789ABCDEF, 1'b0);
        txn("st_top",   1'b1, 64'h3F8, 64'hCAFEF00D12345678, 8'hFF, 64'h0, 1'b0);
        txn("ld_top",   1'b0, 64'h3F8, 64'h0,                8'h00, 64'hCAFEF00D12345678, 1'b0);
        txn("st_20",    1'b1, 64'h20,  64'h0000000000005555, 8'hFF, 64'h0, 1'b0);

        // Backpressure: response held for 5 cycles while a new request is offered.
        rsp_ready_i = 1'b0;
        wait_ready("bp");
        drive_req(1'b0, 64'h20, 64'h0, 8'h00);
        wait_rsp("bp");
        held = rsp_rdata_o;
        check("bp_rdata", held, 64'h5555);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 64'h20;
        req_wdata_i = 64'h9999;
        req_be_i    = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check("bp_valid_held", 64'(rsp_valid_o), 64'd1);
            check("bp_rdata_held", rsp_rdata_o, 64'h5555);
            check("bp_ready_low", 64'(req_ready_o), 64'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_done_valid", 64'(rsp_valid_o), 64'd0);
        check("bp_done_ready", 64'(req_ready_o), 64'd1);
        $display("[TB] backpressure load 0x20 held 5 cycles rdata=0x%h", held);
        txn("ld_after_bp", 1'b0, 64'h20, 64'h0, 8'h00, 64'h5555, 1'b0);

        // Reset one cycle after accepting a store: transaction must vanish.
        wait_ready("rb");
        drive_req(1'b1, 64'h20, 64'hDEAD, 8'hFF);
        check("rb_busy_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("rb_rst_valid", 64'(rsp_valid_o), 64'd0);
        check("rb_rst_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o === 1'b1) seen++;
        end
        check("rb_no_rsp", 64'(seen), 64'd0);
        $display("[TB] reset during BUSY dropped store 0x20");
        txn("ld_after_rb", 1'b0, 64'h20, 64'h0, 8'h00, 64'h5555, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
